// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder with fixed access latency; optional store log under DM_WRITE_LOG_EN
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_pc;
    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic [31:0]      cur_word;
    logic [31:0]      load_data;
    logic [31:0]      merged;
    logic             do_access;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign do_access = (state == WAIT) && (cnt == 4'd0);

    // State register; reset abandons whatever request is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, hold RESP until consumed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access decode: error rules, lane extraction for loads, lane merge for stores
    always_comb begin
        idx      = lat_addr[IDX_W+1:2];
        cur_word = mem[idx];
        case (lat_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = lat_addr[0];
            2'b10:   acc_err = |lat_addr[1:0];
            default: acc_err = 1'b1;
        endcase
        if ({1'b0, lat_addr} >= ADDR_LIMIT) acc_err = 1'b1;
        load_data = '0;
        merged    = cur_word;
        case (lat_size)
            2'b00: begin
                load_data[7:0]                = cur_word[8*lat_addr[1:0] +: 8];
                merged[8*lat_addr[1:0] +: 8]  = lat_wdata[7:0];
            end
            2'b01: begin
                load_data[15:0]               = cur_word[16*lat_addr[1] +: 16];
                merged[16*lat_addr[1] +: 16]  = lat_wdata[15:0];
            end
            default: begin
                load_data = cur_word;
                merged    = lat_wdata;
            end
        endcase
    end

    // Request capture, wait counter, storage update and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_pc    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_pc    <= req_pc;
                cnt       <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || lat_we) ? 32'd0 : load_data;
                if (!acc_err && lat_we) begin
                    mem[idx] <= merged;
`ifdef DM_WRITE_LOG_EN
                    $display("@%08h: *%08h <= %08h", lat_pc, {lat_addr[31:2], 2'b00}, merged);
`endif
                end
            end
        end
    end

`ifndef DM_WRITE_LOG_EN
    logic unused_pc;
    assign unused_pc = ^lat_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - randomized self-checking bench for dm_responder against a byte-array memory model
module tb_dm_responder;

    localparam int WAITC = 2;
    localparam int LAT   = WAITC + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [0:4095];

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    endfunction

    function automatic void model_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                         input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int n;
        rd = 32'd0;
        er = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
             (size == 2'b10 && addr % 4 != 0) || (addr >= 32'd4096);
        if (!er) begin
            n = 1 << size;
            for (int i = 0; i < n; i++) begin
                if (we) mb[addr + i] = wdata[8*i +: 8];
                else    rd[8*i +: 8] = mb[addr + i];
            end
        end
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_size = size; req_addr = addr; req_wdata = wdata; req_pc = $urandom;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 40);
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) @(posedge clk);
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_size = 2'b00; req_addr = '0; req_wdata = '0; req_pc = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, erd; logic er, eer; int lat;
        issue(1'b1, 2'b10, 32'h10, 32'h12345678, 0, rd, er, lat);
        model_access(1'b1, 2'b10, 32'h10, 32'h12345678, erd, eer);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL store_latency got %0d want %0d", lat, LAT); end
        checks++; if ({er, rd} !== {1'b0, 32'd0}) begin errors++; $display("FAIL store_rsp got err=%b rdata=%h want err=0 rdata=0", er, rd); end
        issue(1'b0, 2'b10, 32'h10, 32'h0, 1, rd, er, lat);
        model_access(1'b0, 2'b10, 32'h10, 32'h0, erd, eer);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL load_latency got %0d want %0d", lat, LAT); end
        checks++; if (rd !== 32'h12345678 || er !== 1'b0) begin errors++; $display("FAIL load_word got err=%b rdata=%h want err=0 rdata=12345678", er, rd); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd, erd; logic er, eer; int lat;
        issue(1'b1, 2'b00, 32'h11, 32'hFFFFFFAB, 0, rd, er, lat);
        model_access(1'b1, 2'b00, 32'h11, 32'hFFFFFFAB, erd, eer);
        issue(1'b0, 2'b10, 32'h10, 32'h0, 0, rd, er, lat);
        model_access(1'b0, 2'b10, 32'h10, 32'h0, erd, eer);
        checks++; if (rd !== 32'h1234AB78 || rd !== erd) begin errors++; $display("FAIL byte_merge got %h want 1234ab78 (model %h)", rd, erd); end
        issue(1'b0, 2'b01, 32'h12, 32'h0, 0, rd, er, lat);
        model_access(1'b0, 2'b01, 32'h12, 32'h0, erd, eer);
        checks++; if (rd !== 32'h00001234 || er !== 1'b0) begin errors++; $display("FAIL load_half got err=%b rdata=%h want err=0 rdata=00001234", er, rd); end
        issue(1'b0, 2'b00, 32'h13, 32'h0, 0, rd, er, lat);
        model_access(1'b0, 2'b00, 32'h13, 32'h0, erd, eer);
        checks++; if (rd !== 32'h00000012) begin errors++; $display("FAIL load_byte3 got %h want 00000012", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer; int lat;
        logic [31:0] addrs [6] = '{32'h13, 32'h1001, 32'h1000, 32'h12, 32'hFFC, 32'h40};
        logic [1:0]  sizes [6] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
        logic        wes   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue(wes[i], sizes[i], addrs[i], 32'hCAFEF00D, 0, rd, er, lat);
            model_access(wes[i], sizes[i], addrs[i], 32'hCAFEF00D, erd, eer);
            checks++;
            if (er !== eer || rd !== erd) begin
                errors++;
                $display("FAIL err_case%0d addr=%h size=%b got err=%b rdata=%h want err=%b rdata=%h", i, addrs[i], sizes[i], er, rd, eer, erd);
            end
        end
        issue(1'b0, 2'b10, 32'h10, 32'h0, 0, rd, er, lat);
        model_access(1'b0, 2'b10, 32'h10, 32'h0, erd, eer);
        checks++; if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL err_storage_unchanged got %h want %h", rd, erd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] first, erd; logic eer; int n;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_wdata = '0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
        model_access(1'b0, 2'b10, 32'h10, 32'h0, erd, eer);
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        first = rsp_rdata;
        checks++; if (first !== erd) begin errors++; $display("FAIL bp_rdata got %h want %h", first, erd); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== first || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h ready=%b want 1 %h 0", k, rsp_valid, rsp_rdata, req_ready, first);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_same_edge_accept got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        model_access(1'b1, 2'b10, 32'h30, 32'hDEADBEEF, erd, eer);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_pending_accept got ready=%b want 0", req_ready); end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 40);
        checks++; if (n !== LAT) begin errors++; $display("FAIL bp_second_latency got %0d want %0d", n, LAT); end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd, erd; logic er, eer; int lat;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_idle got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
        issue(1'b0, 2'b10, 32'h20, 32'h0, 0, rd, er, lat);
        model_access(1'b0, 2'b10, 32'h20, 32'h0, erd, eer);
        checks++; if (rd !== 32'd0 || rd !== erd) begin errors++; $display("FAIL rst_wait_no_store got %h want 00000000", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wdata; logic er, eer, we; logic [1:0] size; int lat;
        for (int t = 0; t < 80; t++) begin
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 15) == 0) ? $urandom_range(32'hFF0, 32'h1010) : $urandom_range(0, 32'h3F);
            wdata = $urandom;
            issue(we, size, addr, wdata, $urandom_range(0, 3), rd, er, lat);
            model_access(we, size, addr, wdata, erd, eer);
            checks++;
            if (rd !== erd || er !== eer || lat !== LAT) begin
                errors++;
                $display("FAIL rand%0d we=%b size=%b addr=%h got rdata=%h err=%b lat=%0d want %h %b %0d", t, we, size, addr, rd, er, lat, erd, eer, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: storage size in 32-bit words (4 KiB).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra cycles inserted between request acceptance and access (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned for byte/half.
REQ-011 SHALL have port req_pc  input  32  PC of the issuing instruction, used only for the write log.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-014 SHALL have port rsp_rdata  output  32  load data, right-aligned and zero-extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  request was misaligned, out of range or reserved size.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 SHALL, in IDLE, when req_valid=1, latch we/size/addr/wdata/pc, load counter with WAIT_CYCLES, and enter WAIT on that edge.
REQ-018 SHALL, in WAIT, decrement counter when nonzero; when counter=0, perform access, register rsp_rdata/rsp_err, and enter RESP on the same edge.
REQ-019 SHALL give latency of exactly WAIT_CYCLES+1 cycles from the accepting edge to the edge that raises rsp_valid.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready=1, then return to IDLE; at most one outstanding request.
REQ-021 SHALL ignore req_* inputs outside IDLE; a request held through RESP is accepted only after the return to IDLE (no same-edge RESP->accept).
REQ-022 SHALL flag an error for: size=11; half with addr[0]=1; word with addr[1:0]!=00; addr >= 4*DEPTH_WORDS.
REQ-023 SHALL leave storage unchanged on an error; rsp_rdata=0, rsp_err=1.
REQ-024 SHALL, for a store, write only the addressed lane(s): byte lane addr[1:0] from wdata[7:0]; half lane addr[1] from wdata[15:0]; word all 32 bits.
REQ-025 SHALL, for a load, return word[8*addr[1:0] +: 8] (byte) or word[16*addr[1] +: 16] (half), zero-extended; sign extension is the initiator's job.
REQ-026 SHALL index storage with addr[31:2]; little-endian lane numbering (lane 0 = bits 7:0).

Reset
REQ-027 SHALL, on reset edge: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all storage words 0.
REQ-028 SHALL abandon an in-flight request on reset in WAIT or RESP without writing storage; reset overrides any simultaneous acceptance or consumption.

Configuration
REQ-029 SHALL, with macro DM_WRITE_LOG_EN defined, $display on every successful store the line "@<pc 8 hex>: *<word-aligned addr 8 hex> <= <merged word 8 hex>", printed at the storage-update edge.
REQ-030 SHALL, with DM_WRITE_LOG_EN undefined, print nothing, with identical cycle behaviour and port list.

Verification
REQ-031 SHALL cover store word 0x12345678 @0x10 then load word @0x10, WAIT_CYCLES=2 -> rsp_valid 3 cycles after each accept, load rdata=0x12345678, err=0.
REQ-032 SHALL cover store byte 0xAB @0x11 over word 0x12345678 @0x10 -> word becomes 0x1234AB78; load half @0x12 -> rdata=0x00001234.
REQ-033 SHALL cover load word @0x13 and store half @0x1001 (DEPTH 1024) -> rsp_err=1, rdata=0, storage unchanged.
REQ-034 SHALL cover rsp_ready held low 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, a pending req_valid is not accepted until 1 cycle after rsp_ready.
REQ-035 SHALL cover reset asserted during WAIT of store 0xFFFFFFFF @0x20 -> IDLE next edge, later load @0x20 returns 0.
REQ-036 SHALL cover DM_WRITE_LOG_EN defined, store word 0x5 @0x4 with pc 0x3000 -> exactly one line "@00003000: *00000004 <= 00000005".
